// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at issue, collects CDB results, retires
// in program order to the register file and raises a one-cycle flush on a
// mispredicted branch.
module reorder_buffer #(
    parameter int unsigned ROB_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,

    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic [31:0]      issue_pc,
    input  logic             issue_is_branch,
    input  logic             issue_pred_taken,
    input  logic             issue_ready,
    input  logic [31:0]      issue_value,
    output logic             full,
    output logic [ROB_W-1:0] issue_rob_id,

    output logic             need_set_reg_dep,
    output logic [4:0]       set_dep_reg_id,
    output logic [ROB_W-1:0] set_dep_rob_id,

    output logic             need_set_reg_value,
    output logic [4:0]       set_value_reg_id,
    output logic [31:0]      set_val,
    output logic [ROB_W-1:0] set_reg_rob_id,

    input  logic [ROB_W-1:0] need_rob_id1,
    input  logic [ROB_W-1:0] need_rob_id2,
    output logic             rob_value1_ready,
    output logic [31:0]      rob_value1,
    output logic             rob_value2_ready,
    output logic [31:0]      rob_value2,

    input  logic             wb_valid,
    input  logic [ROB_W-1:0] wb_rob_id,
    input  logic [31:0]      wb_value,
    input  logic             wb_taken,
    input  logic [31:0]      wb_target,

    output logic             clear,
    output logic [31:0]      clear_pc
);

    localparam int unsigned DEPTH = 1 << ROB_W;
    localparam int unsigned CNT_W = ROB_W + 1;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] is_branch;
    logic [DEPTH-1:0] pred_taken;
    logic [DEPTH-1:0] taken;
    logic [4:0]       rd     [DEPTH];
    logic [31:0]      value  [DEPTH];
    logic [31:0]      pc     [DEPTH];
    logic [31:0]      target [DEPTH];

    logic [ROB_W-1:0] head;
    logic [ROB_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic issue_fire;
    logic commit_fire;
    logic wb_fire;
    logic mispredict;

    // Handshake decode for the current cycle
    always_comb begin
        full        = (count == CNT_W'(DEPTH));
        issue_fire  = rdy & issue_valid & ~full & ~clear;
        commit_fire = rdy & ~clear & busy[head] & ready[head];
        wb_fire     = rdy & wb_valid & busy[wb_rob_id];
        mispredict  = commit_fire & is_branch[head] & (taken[head] != pred_taken[head]);
    end

    // Rename and commit requests toward the register file
    always_comb begin
        issue_rob_id       = tail;
        need_set_reg_dep   = issue_fire & (issue_rd != 5'd0);
        set_dep_reg_id     = issue_rd;
        set_dep_rob_id     = tail;
        need_set_reg_value = commit_fire & (rd[head] != 5'd0);
        set_value_reg_id   = rd[head];
        set_val            = value[head];
        set_reg_rob_id     = head;
    end

    // Operand lookups with same-cycle CDB forwarding
    always_comb begin
        rob_value1_ready = ready[need_rob_id1] | (wb_valid & (wb_rob_id == need_rob_id1));
        rob_value1       = (wb_valid & (wb_rob_id == need_rob_id1)) ? wb_value : value[need_rob_id1];
        rob_value2_ready = ready[need_rob_id2] | (wb_valid & (wb_rob_id == need_rob_id2));
        rob_value2       = (wb_valid & (wb_rob_id == need_rob_id2)) ? wb_value : value[need_rob_id2];
    end

    // Entry storage, pointers and flush sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            ready      <= '0;
            is_branch  <= '0;
            pred_taken <= '0;
            taken      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                rd[i]     <= 5'd0;
                value[i]  <= 32'd0;
                pc[i]     <= 32'd0;
                target[i] <= 32'd0;
            end
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            clear    <= 1'b0;
            clear_pc <= 32'd0;
        end else if (rdy) begin
            if (clear) begin
                // Flush: everything younger than the mispredicted branch dies
                busy  <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
                clear <= 1'b0;
            end else begin
                if (wb_fire) begin
                    ready[wb_rob_id]  <= 1'b1;
                    value[wb_rob_id]  <= wb_value;
                    taken[wb_rob_id]  <= wb_taken;
                    target[wb_rob_id] <= wb_target;
                end
                if (issue_fire) begin
                    busy[tail]       <= 1'b1;
                    ready[tail]      <= issue_ready;
                    value[tail]      <= issue_value;
                    rd[tail]         <= issue_rd;
                    pc[tail]         <= issue_pc;
                    is_branch[tail]  <= issue_is_branch;
                    pred_taken[tail] <= issue_pred_taken;
                    taken[tail]      <= 1'b0;
                    target[tail]     <= 32'd0;
                    tail             <= tail + ROB_W'(1);
                end
                if (commit_fire) begin
                    busy[head] <= 1'b0;
                    head       <= head + ROB_W'(1);
                end
                count <= count + CNT_W'(issue_fire) - CNT_W'(commit_fire);
                clear <= mispredict;
                if (mispredict) begin
                    clear_pc <= taken[head] ? target[head] : pc[head] + 32'd4;
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, in-order commit, lookup
// forwarding, mispredict flush, full-with-commit and rdy stalls.
module tb_reorder_buffer;

    localparam int unsigned ROB_W = 3;

    logic             clk;
    logic             rst_n;
    logic             rdy;
    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic [31:0]      issue_pc;
    logic             issue_is_branch;
    logic             issue_pred_taken;
    logic             issue_ready;
    logic [31:0]      issue_value;
    logic             full;
    logic [ROB_W-1:0] issue_rob_id;
    logic             need_set_reg_dep;
    logic [4:0]       set_dep_reg_id;
    logic [ROB_W-1:0] set_dep_rob_id;
    logic             need_set_reg_value;
    logic [4:0]       set_value_reg_id;
    logic [31:0]      set_val;
    logic [ROB_W-1:0] set_reg_rob_id;
    logic [ROB_W-1:0] need_rob_id1;
    logic [ROB_W-1:0] need_rob_id2;
    logic             rob_value1_ready;
    logic [31:0]      rob_value1;
    logic             rob_value2_ready;
    logic [31:0]      rob_value2;
    logic             wb_valid;
    logic [ROB_W-1:0] wb_rob_id;
    logic [31:0]      wb_value;
    logic             wb_taken;
    logic [31:0]      wb_target;
    logic             clear;
    logic [31:0]      clear_pc;

    int checks = 0;
    int errors = 0;

    reorder_buffer #(.ROB_W(ROB_W)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_pc(issue_pc),
        .issue_is_branch(issue_is_branch), .issue_pred_taken(issue_pred_taken),
        .issue_ready(issue_ready), .issue_value(issue_value),
        .full(full), .issue_rob_id(issue_rob_id),
        .need_set_reg_dep(need_set_reg_dep), .set_dep_reg_id(set_dep_reg_id),
        .set_dep_rob_id(set_dep_rob_id),
        .need_set_reg_value(need_set_reg_value), .set_value_reg_id(set_value_reg_id),
        .set_val(set_val), .set_reg_rob_id(set_reg_rob_id),
        .need_rob_id1(need_rob_id1), .need_rob_id2(need_rob_id2),
        .rob_value1_ready(rob_value1_ready), .rob_value1(rob_value1),
        .rob_value2_ready(rob_value2_ready), .rob_value2(rob_value2),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
        .wb_taken(wb_taken), .wb_target(wb_target),
        .clear(clear), .clear_pc(clear_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy = 1'b1;
        issue_valid = 1'b0; issue_rd = 5'd0; issue_pc = 32'd0;
        issue_is_branch = 1'b0; issue_pred_taken = 1'b0;
        issue_ready = 1'b0; issue_value = 32'd0;
        need_rob_id1 = '0; need_rob_id2 = '0;
        wb_valid = 1'b0; wb_rob_id = '0; wb_value = 32'd0;
        wb_taken = 1'b0; wb_target = 32'd0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_issue(input logic [4:0] r, input logic [31:0] p,
                             input logic br, input logic pt,
                             input logic rv, input logic [31:0] v);
        issue_valid = 1'b1; issue_rd = r; issue_pc = p;
        issue_is_branch = br; issue_pred_taken = pt;
        issue_ready = rv; issue_value = v;
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        #1;
        check("rst_full", 32'(full), 32'd0);
        check("rst_rob_id", 32'(issue_rob_id), 32'd0);
        check("rst_clear", 32'(clear), 32'd0);
        check("rst_clear_pc", clear_pc, 32'd0);
        check("rst_dep", 32'(need_set_reg_dep), 32'd0);
        check("rst_val", 32'(need_set_reg_value), 32'd0);

        // ---------------- fill with 8 unresolved instructions ----------------
        for (int i = 0; i < 8; i++) begin
            set_issue(5'(i + 1), 32'(i * 4), 1'b0, 1'b0, 1'b0, 32'd0);
            #1;
            check($sformatf("fill_id%0d", i), 32'(issue_rob_id), 32'(i));
            check($sformatf("fill_dep%0d", i), 32'(need_set_reg_dep), 32'd1);
            check($sformatf("fill_dreg%0d", i), 32'(set_dep_reg_id), 32'(i + 1));
            check($sformatf("fill_drob%0d", i), 32'(set_dep_rob_id), 32'(i));
            check($sformatf("fill_nocommit%0d", i), 32'(need_set_reg_value), 32'd0);
            step();
        end
        set_issue(5'd9, 32'h40, 1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        check("full_after8", 32'(full), 32'd1);
        check("ninth_dep", 32'(need_set_reg_dep), 32'd0);
        step();
        check("ninth_tail", 32'(issue_rob_id), 32'd0);
        check("ninth_full", 32'(full), 32'd1);

        // ---------------- full ROB, head becomes ready ----------------
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_rob_id = 3'd0; wb_value = 32'h55;
        step();
        wb_valid = 1'b0;
        set_issue(5'd9, 32'h40, 1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        check("fc_commit", 32'(need_set_reg_value), 32'd1);
        check("fc_reg", 32'(set_value_reg_id), 32'd1);
        check("fc_val", set_val, 32'h55);
        check("fc_rob", 32'(set_reg_rob_id), 32'd0);
        check("fc_issue_rej", 32'(need_set_reg_dep), 32'd0);
        step();
        check("fc_count7", 32'(dut.count), 32'd7);
        check("fc_notfull", 32'(full), 32'd0);
        check("fc_nxt_id", 32'(issue_rob_id), 32'd0);
        check("fc_nxt_dep", 32'(need_set_reg_dep), 32'd1);
        step();
        check("fc_count8", 32'(dut.count), 32'd8);
        check("fc_full_again", 32'(full), 32'd1);

        // ---------------- out-of-order writeback, in-order commit ----------------
        do_reset();
        set_issue(5'd5, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        set_issue(5'd6, 32'h4, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        idle();
        wb_valid = 1'b1; wb_rob_id = 3'd1; wb_value = 32'h22;
        #1;
        check("ooo_hold1", 32'(need_set_reg_value), 32'd0);
        step();
        wb_rob_id = 3'd0; wb_value = 32'h11;
        #1;
        check("ooo_hold2", 32'(need_set_reg_value), 32'd0);
        step();
        wb_valid = 1'b0;
        #1;
        check("ooo_c0", 32'(need_set_reg_value), 32'd1);
        check("ooo_c0_reg", 32'(set_value_reg_id), 32'd5);
        check("ooo_c0_val", set_val, 32'h11);
        check("ooo_c0_rob", 32'(set_reg_rob_id), 32'd0);
        step();
        check("ooo_c1", 32'(need_set_reg_value), 32'd1);
        check("ooo_c1_reg", 32'(set_value_reg_id), 32'd6);
        check("ooo_c1_val", set_val, 32'h22);
        check("ooo_c1_rob", 32'(set_reg_rob_id), 32'd1);
        step();
        check("ooo_empty", 32'(need_set_reg_value), 32'd0);
        check("ooo_count0", 32'(dut.count), 32'd0);

        // ---------------- lookup forwarding ----------------
        wb_valid = 1'b1; wb_rob_id = 3'd2; wb_value = 32'hABCD;
        need_rob_id1 = 3'd2; need_rob_id2 = 3'd3;
        #1;
        check("lk1_ready", 32'(rob_value1_ready), 32'd1);
        check("lk1_value", rob_value1, 32'hABCD);
        check("lk2_ready", 32'(rob_value2_ready), 32'd0);
        step();
        idle();

        // ---------------- branch mispredict flush ----------------
        do_reset();
        set_issue(5'd0, 32'h100, 1'b1, 1'b0, 1'b0, 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            set_issue(5'(10 + i), 32'(32'h104 + i * 4), 1'b0, 1'b0, 1'b1, 32'(i + 1));
            step();
        end
        idle();
        wb_valid = 1'b1; wb_rob_id = 3'd0; wb_value = 32'd0;
        wb_taken = 1'b1; wb_target = 32'h200;
        step();
        idle();
        #1;
        check("br_commit_norv", 32'(need_set_reg_value), 32'd0);
        check("br_pre_clear", 32'(clear), 32'd0);
        step();
        set_issue(5'd20, 32'h200, 1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        check("br_clear", 32'(clear), 32'd1);
        check("br_clear_pc", clear_pc, 32'h200);
        check("br_young_blocked", 32'(need_set_reg_value), 32'd0);
        check("br_issue_blocked", 32'(need_set_reg_dep), 32'd0);
        step();
        check("br_clear_gone", 32'(clear), 32'd0);
        check("br_count0", 32'(dut.count), 32'd0);
        check("br_next_id", 32'(issue_rob_id), 32'd0);
        check("br_next_dep", 32'(need_set_reg_dep), 32'd1);
        check("br_no_young", 32'(need_set_reg_value), 32'd0);
        step();
        idle();
        #1;
        check("br_after_count", 32'(dut.count), 32'd1);
        check("br_after_nocommit", 32'(need_set_reg_value), 32'd0);

        // ---------------- rdy stall with a ready head ----------------
        do_reset();
        set_issue(5'd7, 32'h0, 1'b0, 1'b0, 1'b1, 32'h77);
        step();
        rdy = 1'b0;
        set_issue(5'd8, 32'h4, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall_val%0d", i), 32'(need_set_reg_value), 32'd0);
            check($sformatf("stall_dep%0d", i), 32'(need_set_reg_dep), 32'd0);
            step();
            check($sformatf("stall_cnt%0d", i), 32'(dut.count), 32'd1);
            check($sformatf("stall_tail%0d", i), 32'(issue_rob_id), 32'd1);
        end
        idle();
        #1;
        check("stall_commit", 32'(need_set_reg_value), 32'd1);
        check("stall_reg", 32'(set_value_reg_id), 32'd7);
        check("stall_val", set_val, 32'h77);
        step();
        check("stall_count0", 32'(dut.count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
